// File: rtl/decode_stage.sv
`default_nettype none
//============================================================================
// Module      : decode_stage
// Description : RV32 instruction decode stage sitting directly upstream of
//               the ALU. Accepts a fetched instruction word and PC over a
//               valid/ready handshake, decodes it combinationally into a
//               one-hot instruction vector, register addresses and a
//               sign-extended immediate, and holds the result in a
//               one-entry pipeline register that feeds execute.
//               Supports backpressure (stall) and flush (branch redirect).
// Config      : `define RV32M_EN to decode the M extension
//               (opcode 0x33, funct7 0x01 -> vector bits 37..44). When it is
//               undefined those encodings are reported as illegal.
// Ports       : clk, rst_n (async, active-low)
//               in_valid/in_ready/in_instr/in_pc   : fetch side
//               flush                               : drop held + incoming
//               out_valid/out_ready                 : execute side
//               out_instructions, out_rs1_addr, out_rs2_addr, out_rd_addr,
//               out_imm, out_pc, out_illegal         : decoded instruction
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps

module decode_stage #(
  parameter int              XLEN     = 32,
  parameter int              INSTR_W  = 47,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [XLEN-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instructions,
  output logic [4:0]         out_rs1_addr,
  output logic [4:0]         out_rs2_addr,
  output logic [4:0]         out_rd_addr,
  output logic [XLEN-1:0]    out_imm,
  output logic [XLEN-1:0]    out_pc,
  output logic               out_illegal
);

  // Opcodes of the supported RV32I/M major groups
  localparam logic [6:0] c_OP_R      = 7'h33;
  localparam logic [6:0] c_OP_IMM    = 7'h13;
  localparam logic [6:0] c_OP_LOAD   = 7'h03;
  localparam logic [6:0] c_OP_STORE  = 7'h23;
  localparam logic [6:0] c_OP_BRANCH = 7'h63;
  localparam logic [6:0] c_OP_JAL    = 7'h6F;
  localparam logic [6:0] c_OP_JALR   = 7'h67;
  localparam logic [6:0] c_OP_LUI    = 7'h37;
  localparam logic [6:0] c_OP_AUIPC  = 7'h17;
  localparam logic [6:0] c_OP_FENCE  = 7'h0F;
  localparam logic [6:0] c_OP_SYSTEM = 7'h73;

  localparam logic [31:0] c_ECALL  = 32'h0000_0073;
  localparam logic [31:0] c_EBREAK = 32'h0010_0073;

  // ---------------------------------------------------------------------
  // Field extraction and immediate formats
  // ---------------------------------------------------------------------
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_sh;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];

  assign w_imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  // imm[12] of a branch is instr[31], so it is covered by the sign copies
  assign w_imm_b  = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
  // imm[20] of a jump is instr[31], likewise covered by the sign copies
  assign w_imm_j  = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
  assign w_imm_u  = {in_instr[31:12], 12'b0};
  assign w_imm_sh = {27'b0, in_instr[24:20]};

  // ---------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------
  logic [INSTR_W-1:0] w_vec;
  logic               w_legal;
  logic               w_use_rs1;
  logic               w_use_rs2;
  logic               w_use_rd;
  logic [31:0]        w_imm_sel;

  always_comb begin
    w_vec     = '0;
    w_legal   = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_rd  = 1'b0;
    w_imm_sel = '0;

    case (w_opcode)
      c_OP_R: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_use_rd  = 1'b1;
        if (w_funct7 == 7'h00) begin
          w_legal = 1'b1;
          case (w_funct3)
            3'd0:    w_vec[0] = 1'b1;  // ADD
            3'd1:    w_vec[5] = 1'b1;  // SLL
            3'd2:    w_vec[8] = 1'b1;  // SLT
            3'd3:    w_vec[9] = 1'b1;  // SLTU
            3'd4:    w_vec[2] = 1'b1;  // XOR
            3'd5:    w_vec[6] = 1'b1;  // SRL
            3'd6:    w_vec[3] = 1'b1;  // OR
            default: w_vec[4] = 1'b1;  // AND
          endcase
        end else if (w_funct7 == 7'h20) begin
          if (w_funct3 == 3'd0) begin
            w_legal  = 1'b1;
            w_vec[1] = 1'b1;           // SUB
          end else if (w_funct3 == 3'd5) begin
            w_legal  = 1'b1;
            w_vec[7] = 1'b1;           // SRA
          end
        end
`ifdef RV32M_EN
        else if (w_funct7 == 7'h01) begin
          w_legal = 1'b1;
          case (w_funct3)
            3'd0:    w_vec[37] = 1'b1; // MUL
            3'd1:    w_vec[38] = 1'b1; // MULH
            3'd2:    w_vec[39] = 1'b1; // MULHSU
            3'd3:    w_vec[40] = 1'b1; // MULHU
            3'd4:    w_vec[41] = 1'b1; // DIV
            3'd5:    w_vec[42] = 1'b1; // DIVU
            3'd6:    w_vec[43] = 1'b1; // REM
            default: w_vec[44] = 1'b1; // REMU
          endcase
        end
`endif
      end

      c_OP_IMM: begin
        w_use_rs1 = 1'b1;
        w_use_rd  = 1'b1;
        w_imm_sel = w_imm_i;
        case (w_funct3)
          3'd0: begin w_legal = 1'b1; w_vec[10] = 1'b1; end  // ADDI
          3'd2: begin w_legal = 1'b1; w_vec[17] = 1'b1; end  // SLTI
          3'd3: begin w_legal = 1'b1; w_vec[18] = 1'b1; end  // SLTIU
          3'd4: begin w_legal = 1'b1; w_vec[11] = 1'b1; end  // XORI
          3'd6: begin w_legal = 1'b1; w_vec[12] = 1'b1; end  // ORI
          3'd7: begin w_legal = 1'b1; w_vec[13] = 1'b1; end  // ANDI
          3'd1: begin
            // Shift immediates carry only a 5-bit shamt; upper bits select the op
            w_imm_sel = w_imm_sh;
            if (w_funct7 == 7'h00) begin
              w_legal   = 1'b1;
              w_vec[14] = 1'b1;        // SLLI
            end
          end
          default: begin
            w_imm_sel = w_imm_sh;
            if (w_funct7 == 7'h00) begin
              w_legal   = 1'b1;
              w_vec[15] = 1'b1;        // SRLI
            end else if (w_funct7 == 7'h20) begin
              w_legal   = 1'b1;
              w_vec[16] = 1'b1;        // SRAI
            end
          end
        endcase
      end

      c_OP_LOAD: begin
        w_use_rs1 = 1'b1;
        w_use_rd  = 1'b1;
        w_imm_sel = w_imm_i;
        case (w_funct3)
          3'd0:    begin w_legal = 1'b1; w_vec[19] = 1'b1; end  // LB
          3'd1:    begin w_legal = 1'b1; w_vec[20] = 1'b1; end  // LH
          3'd2:    begin w_legal = 1'b1; w_vec[21] = 1'b1; end  // LW
          3'd4:    begin w_legal = 1'b1; w_vec[22] = 1'b1; end  // LBU
          3'd5:    begin w_legal = 1'b1; w_vec[23] = 1'b1; end  // LHU
          default: ;
        endcase
      end

      c_OP_STORE: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_imm_sel = w_imm_s;
        case (w_funct3)
          3'd0:    begin w_legal = 1'b1; w_vec[24] = 1'b1; end  // SB
          3'd1:    begin w_legal = 1'b1; w_vec[25] = 1'b1; end  // SH
          3'd2:    begin w_legal = 1'b1; w_vec[26] = 1'b1; end  // SW
          default: ;
        endcase
      end

      c_OP_BRANCH: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_imm_sel = w_imm_b;
        case (w_funct3)
          3'd0:    begin w_legal = 1'b1; w_vec[27] = 1'b1; end  // BEQ
          3'd1:    begin w_legal = 1'b1; w_vec[28] = 1'b1; end  // BNE
          3'd4:    begin w_legal = 1'b1; w_vec[29] = 1'b1; end  // BLT
          3'd5:    begin w_legal = 1'b1; w_vec[30] = 1'b1; end  // BGE
          3'd6:    begin w_legal = 1'b1; w_vec[31] = 1'b1; end  // BLTU
          3'd7:    begin w_legal = 1'b1; w_vec[32] = 1'b1; end  // BGEU
          default: ;
        endcase
      end

      c_OP_JAL: begin
        w_legal   = 1'b1;
        w_use_rd  = 1'b1;
        w_imm_sel = w_imm_j;
        w_vec[33] = 1'b1;
      end

      c_OP_JALR: begin
        if (w_funct3 == 3'd0) begin
          w_legal   = 1'b1;
          w_use_rs1 = 1'b1;
          w_use_rd  = 1'b1;
          w_imm_sel = w_imm_i;
          w_vec[34] = 1'b1;
        end
      end

      c_OP_LUI: begin
        w_legal   = 1'b1;
        w_use_rd  = 1'b1;
        w_imm_sel = w_imm_u;
        w_vec[35] = 1'b1;
      end

      c_OP_AUIPC: begin
        w_legal   = 1'b1;
        w_use_rd  = 1'b1;
        w_imm_sel = w_imm_u;
        w_vec[36] = 1'b1;
      end

      // FENCE has no effect on an in-order single-issue core: legal NOP
      c_OP_FENCE: begin
        if (w_funct3 == 3'd0) begin
          w_legal = 1'b1;
        end
      end

      // Only the two exact environment-call encodings are supported
      c_OP_SYSTEM: begin
        if (in_instr == c_ECALL) begin
          w_legal   = 1'b1;
          w_vec[45] = 1'b1;
        end else if (in_instr == c_EBREAK) begin
          w_legal   = 1'b1;
          w_vec[46] = 1'b1;
        end
      end

      default: ;
    endcase
  end

  // Illegal encodings present an all-zero payload
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic [31:0] w_imm;

  assign w_rs1 = (w_legal && w_use_rs1) ? in_instr[19:15] : 5'd0;
  assign w_rs2 = (w_legal && w_use_rs2) ? in_instr[24:20] : 5'd0;
  assign w_rd  = (w_legal && w_use_rd)  ? in_instr[11:7]  : 5'd0;
  assign w_imm = w_legal ? w_imm_sel : 32'd0;

  // ---------------------------------------------------------------------
  // Handshake and pipeline register
  // ---------------------------------------------------------------------
  logic               r_valid;
  logic [INSTR_W-1:0] r_vec;
  logic [4:0]         r_rs1;
  logic [4:0]         r_rs2;
  logic [4:0]         r_rd;
  logic [XLEN-1:0]    r_imm;
  logic [XLEN-1:0]    r_pc;
  logic               r_illegal;
  logic               w_accept;

  assign in_ready = !flush && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Flush has priority; payload registers only move on accept so a stalled
  // instruction stays bit-stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_vec     <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_imm     <= '0;
      r_pc      <= RESET_PC;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_vec     <= w_vec;
      r_rs1     <= w_rs1;
      r_rs2     <= w_rs2;
      r_rd      <= w_rd;
      r_imm     <= XLEN'($signed(w_imm));
      r_pc      <= in_pc;
      r_illegal <= !w_legal;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid        = r_valid;
  assign out_instructions = r_vec;
  assign out_rs1_addr     = r_rs1;
  assign out_rs2_addr     = r_rs2;
  assign out_rd_addr      = r_rd;
  assign out_imm          = r_imm;
  assign out_pc           = r_pc;
  assign out_illegal      = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
//============================================================================
// Module      : tb_decode_stage
// Description : Self-checking bench for decode_stage. Expected decode comes
//               from a mask/match instruction table with format-driven
//               field extraction; handshake expectations from a one-entry
//               occupancy model.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps

module tb_decode_stage;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [46:0] out_instructions;
  logic [4:0]  out_rs1_addr;
  logic [4:0]  out_rs2_addr;
  logic [4:0]  out_rd_addr;
  logic [31:0] out_imm;
  logic [31:0] out_pc;
  logic        out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_stage #(
    .XLEN     (32),
    .INSTR_W  (47),
    .RESET_PC (RST_PC)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_instr         (in_instr),
    .in_pc            (in_pc),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instructions (out_instructions),
    .out_rs1_addr     (out_rs1_addr),
    .out_rs2_addr     (out_rs2_addr),
    .out_rd_addr      (out_rd_addr),
    .out_imm          (out_imm),
    .out_pc           (out_pc),
    .out_illegal      (out_illegal)
  );

  // ---------------------------------------------------------------------
  // Reference model: instruction table
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic [46:0] vec;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ill;
  } dec_t;

  typedef enum int {F_R, F_I, F_SH, F_S, F_B, F_U, F_J, F_N} fmt_e;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    int          bitn;
    fmt_e        fmt;
  } pat_t;

  pat_t tbl[$];

  function automatic void add(logic [31:0] mask, logic [31:0] match, int bitn, fmt_e fmt);
    pat_t p;
    p.mask  = mask;
    p.match = match;
    p.bitn  = bitn;
    p.fmt   = fmt;
    tbl.push_back(p);
  endfunction

  function automatic void build_table();
    add(32'hFE00707F, 32'h00000033,  0, F_R);  // ADD
    add(32'hFE00707F, 32'h40000033,  1, F_R);  // SUB
    add(32'hFE00707F, 32'h00004033,  2, F_R);  // XOR
    add(32'hFE00707F, 32'h00006033,  3, F_R);  // OR
    add(32'hFE00707F, 32'h00007033,  4, F_R);  // AND
    add(32'hFE00707F, 32'h00001033,  5, F_R);  // SLL
    add(32'hFE00707F, 32'h00005033,  6, F_R);  // SRL
    add(32'hFE00707F, 32'h40005033,  7, F_R);  // SRA
    add(32'hFE00707F, 32'h00002033,  8, F_R);  // SLT
    add(32'hFE00707F, 32'h00003033,  9, F_R);  // SLTU
    add(32'h0000707F, 32'h00000013, 10, F_I);  // ADDI
    add(32'h0000707F, 32'h00004013, 11, F_I);  // XORI
    add(32'h0000707F, 32'h00006013, 12, F_I);  // ORI
    add(32'h0000707F, 32'h00007013, 13, F_I);  // ANDI
    add(32'hFE00707F, 32'h00001013, 14, F_SH); // SLLI
    add(32'hFE00707F, 32'h00005013, 15, F_SH); // SRLI
    add(32'hFE00707F, 32'h40005013, 16, F_SH); // SRAI
    add(32'h0000707F, 32'h00002013, 17, F_I);  // SLTI
    add(32'h0000707F, 32'h00003013, 18, F_I);  // SLTIU
    add(32'h0000707F, 32'h00000003, 19, F_I);  // LB
    add(32'h0000707F, 32'h00001003, 20, F_I);  // LH
    add(32'h0000707F, 32'h00002003, 21, F_I);  // LW
    add(32'h0000707F, 32'h00004003, 22, F_I);  // LBU
    add(32'h0000707F, 32'h00005003, 23, F_I);  // LHU
    add(32'h0000707F, 32'h00000023, 24, F_S);  // SB
    add(32'h0000707F, 32'h00001023, 25, F_S);  // SH
    add(32'h0000707F, 32'h00002023, 26, F_S);  // SW
    add(32'h0000707F, 32'h00000063, 27, F_B);  // BEQ
    add(32'h0000707F, 32'h00001063, 28, F_B);  // BNE
    add(32'h0000707F, 32'h00004063, 29, F_B);  // BLT
    add(32'h0000707F, 32'h00005063, 30, F_B);  // BGE
    add(32'h0000707F, 32'h00006063, 31, F_B);  // BLTU
    add(32'h0000707F, 32'h00007063, 32, F_B);  // BGEU
    add(32'h0000007F, 32'h0000006F, 33, F_J);  // JAL
    add(32'h0000707F, 32'h00000067, 34, F_I);  // JALR
    add(32'h0000007F, 32'h00000037, 35, F_U);  // LUI
    add(32'h0000007F, 32'h00000017, 36, F_U);  // AUIPC
`ifdef RV32M_EN
    for (int k = 0; k < 8; k++)
      add(32'hFE00707F, 32'h02000033 | (32'(k) << 12), 37 + k, F_R);
`endif
    add(32'hFFFFFFFF, 32'h00000073, 45, F_N);  // ECALL
    add(32'hFFFFFFFF, 32'h00100073, 46, F_N);  // EBREAK
    add(32'h0000707F, 32'h0000000F, -1, F_N);  // FENCE (NOP)
  endfunction

  function automatic dec_t ref_decode(logic [31:0] w);
    dec_t             d;
    int               hit = -1;
    logic signed [31:0] s;
    s = w;
    d = '0;
    d.ill = 1'b1;
    foreach (tbl[i]) if ((w & tbl[i].mask) == tbl[i].match) hit = i;
    if (hit < 0) return d;
    d.ill = 1'b0;
    if (tbl[hit].bitn >= 0) d.vec[tbl[hit].bitn] = 1'b1;
    case (tbl[hit].fmt)
      F_R:  begin d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.rd = w[11:7]; end
      F_I:  begin d.rs1 = w[19:15]; d.rd = w[11:7]; d.imm = 32'(s >>> 20); end
      F_SH: begin d.rs1 = w[19:15]; d.rd = w[11:7]; d.imm = (w >> 20) & 32'd31; end
      F_S:  begin
        d.rs1 = w[19:15]; d.rs2 = w[24:20];
        d.imm = 32'((s >>> 25) << 5) | ((w >> 7) & 32'd31);
      end
      F_B:  begin
        d.rs1 = w[19:15]; d.rs2 = w[24:20];
        d.imm = 32'((s >>> 31) << 12) | (((w >> 7) & 32'd1) << 11) |
                (((w >> 25) & 32'd63) << 5) | (((w >> 8) & 32'd15) << 1);
      end
      F_U:  begin d.rd = w[11:7]; d.imm = w & 32'hFFFFF000; end
      F_J:  begin
        d.rd  = w[11:7];
        d.imm = 32'((s >>> 31) << 20) | (((w >> 12) & 32'd255) << 12) |
                (((w >> 20) & 32'd1) << 11) | (((w >> 21) & 32'd1023) << 1);
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] gen_instr();
    int r;
    int idx;
    r = int'($urandom_range(0, 9));
    if (r == 0) return $urandom;
    if (r == 1) return 32'h02000033 | ($urandom & 32'h01FFFF80);  // M-extension space
    idx = int'($urandom_range(0, tbl.size() - 1));
    return tbl[idx].match | ($urandom & ~tbl[idx].mask);
  endfunction

  function automatic dec_t dut_out();
    return {out_instructions, out_rs1_addr, out_rs2_addr, out_rd_addr, out_imm, out_illegal};
  endfunction

  // ---------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++;
    if (dut_out() !== dec_t'(0)) begin n_fail++; $display("FAIL reset_payload: got %h want 0", dut_out()); end
    n_checks++;
    if (out_pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", out_pc, RST_PC); end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] ins [10];
    dec_t        exp;
    logic [31:0] pc;
    ins[0] = 32'h002081B3;  // ADD x3,x1,x2
    ins[1] = 32'hFFF00093;  // ADDI x1,x0,-1
    ins[2] = 32'h00208463;  // BEQ x1,x2,+8
    ins[3] = 32'h022081B3;  // MUL x3,x1,x2
    ins[4] = 32'hFFFFFFFF;
    ins[5] = 32'h0000000F;  // FENCE
    ins[6] = 32'h00000073;  // ECALL
    ins[7] = 32'h00100073;  // EBREAK
    ins[8] = 32'h40735293;  // SRAI x5,x6,7
    ins[9] = 32'h40001013;  // SLLI with funct7=0x20
    out_ready = 1'b1; flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_instr = ins[i];
      pc       = 32'h100 + 32'(4 * i);
      in_pc    = pc;
      exp      = ref_decode(ins[i]);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dir_in_ready[%0d]: got %b want 1", i, in_ready); end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || dut_out() !== exp || out_pc !== pc) begin
        n_fail++;
        $display("FAIL dir_decode[%0d]: got v=%b %h pc=%h want v=1 %h pc=%h", i, out_valid, dut_out(), out_pc, exp, pc);
      end
      if (i == 0) begin
        n_checks++;
        if ({out_instructions, out_rs1_addr, out_rs2_addr, out_rd_addr, out_imm} !== {47'h1, 5'd1, 5'd2, 5'd3, 32'd0}) begin
          n_fail++; $display("FAIL dir_add_literal: got %h %0d %0d %0d %h", out_instructions, out_rs1_addr, out_rs2_addr, out_rd_addr, out_imm);
        end
      end
      if (i == 1) begin
        n_checks++;
        if ({out_instructions, out_rs1_addr, out_rd_addr, out_imm} !== {47'h1 << 10, 5'd0, 5'd1, 32'hFFFFFFFF}) begin
          n_fail++; $display("FAIL dir_addi_literal: got %h %0d %0d %h", out_instructions, out_rs1_addr, out_rd_addr, out_imm);
        end
      end
      if (i == 2) begin
        n_checks++;
        if ({out_instructions, out_rd_addr, out_imm} !== {47'h1 << 27, 5'd0, 32'h8}) begin
          n_fail++; $display("FAIL dir_beq_literal: got %h %0d %h", out_instructions, out_rd_addr, out_imm);
        end
      end
      if (i == 3) begin
        n_checks++;
`ifdef RV32M_EN
        if ({out_instructions, out_illegal} !== {47'h1 << 37, 1'b0}) begin
`else
        if ({out_instructions, out_illegal} !== {47'h0, 1'b1}) begin
`endif
          n_fail++; $display("FAIL dir_mul_literal: got %h ill=%b", out_instructions, out_illegal);
        end
      end
      if (i == 4) begin
        n_checks++;
        if (out_illegal !== 1'b1 || out_instructions !== 47'h0) begin
          n_fail++; $display("FAIL dir_allones_literal: got ill=%b vec=%h want ill=1 vec=0", out_illegal, out_instructions);
        end
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    dec_t exp_add;
    dec_t exp_addi;
    exp_add  = ref_decode(32'h002081B3);
    exp_addi = ref_decode(32'hFFF00093);
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h200;
    @(posedge clk); #1;
    out_ready = 1'b0; in_instr = 32'hFFF00093; in_pc = 32'h204;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %b want 0", c, in_ready); end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || dut_out() !== exp_add || out_pc !== 32'h200) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got v=%b %h pc=%h want v=1 %h pc=200", c, out_valid, dut_out(), out_pc, exp_add);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || dut_out() !== exp_addi || out_pc !== 32'h204) begin
      n_fail++; $display("FAIL stall_next: got v=%b %h pc=%h want v=1 %h pc=204", out_valid, dut_out(), out_pc, exp_addi);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00208463; in_pc = 32'h300;
    @(posedge clk); #1;
    out_ready = 1'b0; in_instr = 32'h002081B3; in_pc = 32'h304; flush = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_clear: got %b want 0", out_valid); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got %b want 0", out_valid); end
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %b want 0", out_valid); end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit          m_valid = 1'b0;
    dec_t        m_dec = '0;
    logic [31:0] m_pc = '0;
    bit          exp_ready;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_instr  = gen_instr();
      in_pc     = $urandom & 32'hFFFFFFFC;
      #1;
      exp_ready = !flush && (!m_valid || out_ready);
      n_checks++;
      if (in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", c, in_ready, exp_ready); end
      if (flush) m_valid = 1'b0;
      else if (in_valid && exp_ready) begin
        m_valid = 1'b1;
        m_dec   = ref_decode(in_instr);
        m_pc    = in_pc;
      end else if (out_ready) m_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, out_valid, m_valid); end
      if (m_valid) begin
        n_checks++;
        if (dut_out() !== m_dec || out_pc !== m_pc) begin
          n_fail++; $display("FAIL rnd_payload[%0d]: got %h pc=%h want %h pc=%h", c, dut_out(), out_pc, m_dec, m_pc);
        end
      end
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    dec_t exp;
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h500;
    @(posedge clk); #1;
    out_ready = 1'b0; in_instr = 32'hFFF00093;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || dut_out() !== dec_t'(0) || out_pc !== RST_PC) begin
      n_fail++; $display("FAIL async_reset: got v=%b %h pc=%h want v=0 0 pc=%h", out_valid, dut_out(), out_pc, RST_PC);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h600; out_ready = 1'b1;
    exp = ref_decode(32'h002081B3);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || dut_out() !== exp || out_pc !== 32'h600) begin
      n_fail++; $display("FAIL post_reset_decode: got v=%b %h pc=%h want v=1 %h pc=600", out_valid, dut_out(), out_pc, exp);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    build_table();
    test_reset();
    test_directed();
    test_stall();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
